// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: fetch-side bundle between branch resolution, the PC sequencer and instruction memory
//   in_take/in_target     redirect request and resolved target
//   in_stall              downstream hazard stall
//   in_fetch_ready        instruction memory accepts out_pc
//   out_pc/out_fetch_valid fetch request
//   out_squash/out_flush_busy wrong-path marking while flushing
interface pc_sequencer_if #(parameter int PC_WIDTH = 32);
   logic                in_take;
   logic [PC_WIDTH-1:0] in_target;
   logic                in_stall;
   logic                in_fetch_ready;
   logic [PC_WIDTH-1:0] out_pc;
   logic                out_fetch_valid;
   logic                out_squash;
   logic                out_flush_busy;
   modport master (
      output in_take, in_target, in_stall, in_fetch_ready,
      input  out_pc, out_fetch_valid, out_squash, out_flush_busy
   );
   modport slave (
      input  in_take, in_target, in_stall, in_fetch_ready,
      output out_pc, out_fetch_valid, out_squash, out_flush_busy
   );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter and fetch sequencer with redirect-driven wrong-path flush
//   in_clk    clock, rising edge
//   in_rst_n  synchronous reset, active low
//   bus       pc_sequencer_if.slave: redirect/stall/ready in, fetch request and squash out
module pc_sequencer #(
   parameter int                  PC_WIDTH    = 32,
   parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
   parameter logic [PC_WIDTH-1:0] PC_INC      = PC_WIDTH'(1),
   parameter int unsigned         FLUSH_SLOTS = 2
) (
   input logic             in_clk,
   input logic             in_rst_n,
   pc_sequencer_if.slave   bus
);
   typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;
   state_t              r_state, w_state_nxt;
   logic [2:0]          r_cnt, w_cnt_nxt;
   logic [PC_WIDTH-1:0] r_pc, w_pc_nxt;
   logic                w_valid, w_accept, w_redirect;
   assign w_valid    = r_state != BOOT;
   assign w_accept   = w_valid & bus.in_fetch_ready & ~bus.in_stall;
   // a redirect wins over both stall and a not-ready memory
   assign w_redirect = w_valid & bus.in_take;
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_pc_nxt    = w_accept ? r_pc + PC_INC : r_pc;
      if (w_redirect) begin
         w_pc_nxt    = bus.in_target;
         w_state_nxt = FLUSH;
         w_cnt_nxt   = 3'(FLUSH_SLOTS);
      end else if (r_state == BOOT) begin
         w_state_nxt = RUN;
      end else if (r_state == FLUSH && !bus.in_stall) begin
         // the flush window only counts down on unstalled cycles
         w_state_nxt = (r_cnt == 3'd1) ? RUN : FLUSH;
         w_cnt_nxt   = r_cnt - 3'd1;
      end
   end
   always_ff @(posedge in_clk) begin
      if (!in_rst_n) begin
         r_state <= BOOT;
         r_cnt   <= '0;
         r_pc    <= RESET_PC;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_pc    <= w_pc_nxt;
      end
   end
   assign bus.out_pc          = r_pc;
   assign bus.out_fetch_valid = w_valid;
   assign bus.out_squash      = r_state == FLUSH;
   assign bus.out_flush_busy  = r_state == FLUSH;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scoreboard bench for pc_sequencer
module tb_pc_sequencer;
   logic clk = 0;
   logic rst_n = 0;
   int   n_chk = 0;
   int   n_pass = 0;
   typedef struct {
      string       tag;
      logic [31:0] pc;
      logic        v;
      logic        sq;
   } exp_t;
   exp_t q[$];
   pc_sequencer_if #(.PC_WIDTH(32)) bus();
   pc_sequencer #(.PC_WIDTH(32)) dut (.in_clk(clk), .in_rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      assert (act === exp) n_pass++;
      else $error("FAIL %s: got %h expected %h", tag, act, exp);
   endtask
   // drive one cycle of inputs, queue the state expected after the edge, then compare
   task automatic step(input string tag, input logic rn, input logic take, input logic stall,
                       input logic rdy, input logic [31:0] tgt,
                       input logic [31:0] epc, input logic ev, input logic esq);
      exp_t e;
      rst_n              = rn;
      bus.in_take        = take;
      bus.in_stall       = stall;
      bus.in_fetch_ready = rdy;
      bus.in_target      = tgt;
      q.push_back('{tag, epc, ev, esq});
      @(posedge clk);
      #1;
      e = q.pop_front();
      chk({e.tag, ".pc"},     bus.out_pc,                   e.pc);
      chk({e.tag, ".valid"},  32'(bus.out_fetch_valid),     32'(e.v));
      chk({e.tag, ".squash"}, 32'(bus.out_squash),          32'(e.sq));
      chk({e.tag, ".busy"},   32'(bus.out_flush_busy),      32'(e.sq));
   endtask
   initial begin
      bus.in_take = 0; bus.in_stall = 0; bus.in_fetch_ready = 1; bus.in_target = '0;
      // reset held three cycles, then BOOT for one cycle, then sequential fetch
      step("rst0",  0, 0, 0, 1, 0, 0, 0, 0);
      step("rst1",  0, 0, 0, 1, 0, 0, 0, 0);
      step("rst2",  0, 0, 0, 1, 0, 0, 0, 0);
      step("boot",  1, 0, 0, 1, 0, 0, 1, 0);
      step("seq1",  1, 0, 0, 1, 0, 1, 1, 0);
      step("seq2",  1, 0, 0, 1, 0, 2, 1, 0);
      step("seq3",  1, 0, 0, 1, 0, 3, 1, 0);
      step("seq4",  1, 0, 0, 1, 0, 4, 1, 0);
      step("seq5",  1, 0, 0, 1, 0, 5, 1, 0);
      // memory not ready: request held at 5
      step("nrdy1", 1, 0, 0, 0, 0, 5, 1, 0);
      step("nrdy2", 1, 0, 0, 0, 0, 5, 1, 0);
      step("rdy6",  1, 0, 0, 1, 0, 6, 1, 0);
      step("seq7",  1, 0, 0, 1, 0, 7, 1, 0);
      step("seq8",  1, 0, 0, 1, 0, 8, 1, 0);
      // plain redirect: two squashed fetches, then 0x42 clean
      step("jmp40", 1, 1, 0, 1, 32'h40, 32'h40, 1, 1);
      step("fl41",  1, 0, 0, 1, 0, 32'h41, 1, 1);
      step("run42", 1, 0, 0, 1, 0, 32'h42, 1, 0);
      step("run43", 1, 0, 0, 1, 0, 32'h43, 1, 0);
      // redirect under stall: PC and count frozen until the stall drops
      step("jst100", 1, 1, 1, 1, 32'h100, 32'h100, 1, 1);
      step("st1",    1, 0, 1, 1, 0, 32'h100, 1, 1);
      step("st2",    1, 0, 1, 1, 0, 32'h100, 1, 1);
      step("fl101",  1, 0, 0, 1, 0, 32'h101, 1, 1);
      step("run102", 1, 0, 0, 1, 0, 32'h102, 1, 0);
      // second redirect one cycle into FLUSH, with memory not ready: count reloads
      step("jmp60",  1, 1, 0, 1, 32'h60, 32'h60, 1, 1);
      step("jmp80",  1, 1, 0, 0, 32'h80, 32'h80, 1, 1);
      step("fl81",   1, 0, 0, 1, 0, 32'h81, 1, 1);
      step("run82",  1, 0, 0, 1, 0, 32'h82, 1, 0);
      // wrap-around from all-ones
      step("jmpff",  1, 1, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1);
      step("wrap0",  1, 0, 0, 1, 0, 0, 1, 1);
      step("run1",   1, 0, 0, 1, 0, 1, 1, 0);
      // reset in the middle of a flush, with a redirect pending
      step("jmp200", 1, 1, 0, 1, 32'h200, 32'h200, 1, 1);
      step("rstfl",  0, 1, 0, 1, 32'h300, 0, 0, 0);
      // redirect ignored in BOOT
      step("bootj",  1, 1, 0, 1, 32'h77, 0, 1, 0);
      step("post1",  1, 0, 0, 1, 0, 1, 1, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
